// File: rtl/cellcore_cfg_loader_if.sv
// Programming-side bundle for the cellcore configuration loader.
// Combinational wiring only, no latency.
// tready_v is the only backpressure: bits offered while it is low are not taken.
interface cellcore_cfg_loader_if #(
    parameter int NCELLS = 16
);
    logic                   start_v;
    logic                   abort_v;
    logic                   tdi_v;
    logic                   tvalid_v;
    logic                   tready_v;
    logic                   busy_v;
    logic                   done_v;
    logic                   err_v;
    logic [NCELLS*20-1:0]   cfg_mux;

    // Programming interface / bitstream source side
    modport master (
        output start_v,
        output abort_v,
        output tdi_v,
        output tvalid_v,
        input  tready_v,
        input  busy_v,
        input  done_v,
        input  err_v,
        input  cfg_mux
    );

    // Loader side
    modport slave (
        input  start_v,
        input  abort_v,
        input  tdi_v,
        input  tvalid_v,
        output tready_v,
        output busy_v,
        output done_v,
        output err_v,
        output cfg_mux
    );
endinterface

// File: rtl/cellcore_cfg_loader.sv
// Serial config loader: shifts 21-bit parity-checked frames per cell into a shadow, commits all cells atomically.
// One bit per accepted handshake; commit lands one cycle after the last parity bit (1 + 21*NCELLS + 1 minimum).
// tready_v is high only while shifting; gaps in tvalid_v simply stall the frame without changing state.
module cellcore_cfg_loader #(
    parameter int NCELLS = 16,
    parameter int CFGW   = 20
) (
    input  logic                   clk_v,
    input  logic                   rstn_v,
    cellcore_cfg_loader_if.slave   cfg_if
);

    localparam int SW = NCELLS * CFGW;
    localparam int CW = (NCELLS > 1) ? $clog2(NCELLS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [4:0]    PAR_BIT   = 5'(CFGW);
    localparam logic [CW-1:0] LAST_CELL = CW'(NCELLS - 1);

    // Elaboration-time guard on the fixed frame geometry and array size
    if (CFGW != 20) begin : g_bad_cfgw
        $error("cellcore_cfg_loader: CFGW must be 20");
    end
    if (NCELLS < 1 || NCELLS > 64) begin : g_bad_ncells
        $error("cellcore_cfg_loader: NCELLS must be in 1..64");
    end

    logic [1:0]    state_q,  state_d;
    logic [4:0]    bit_q,    bit_d;
    logic [CW-1:0] cell_q,   cell_d;
    logic          par_q,    par_d;
    logic          err_q,    err_d;
    logic          done_q,   done_d;
    logic [SW-1:0] shadow_q, shadow_d;
    logic [SW-1:0] cfg_q,    cfg_d;

    logic          accept;

    assign accept = (state_q == ST_SHIFT) && cfg_if.tvalid_v;

    // Next-state logic: frame assembly, parity check and the atomic commit
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        cell_d   = cell_q;
        par_d    = par_q;
        err_d    = err_q;
        done_d   = 1'b0;
        shadow_d = shadow_q;
        cfg_d    = cfg_q;

        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort here; abort has nothing to cancel
                if (cfg_if.start_v) begin
                    state_d  = ST_SHIFT;
                    err_d    = 1'b0;
                    bit_d    = 5'd0;
                    cell_d   = '0;
                    par_d    = 1'b0;
                    shadow_d = '0;
                end
            end

            ST_SHIFT: begin
                if (cfg_if.abort_v) begin
                    // Shadow contents are dropped; the next start clears them anyway
                    state_d = ST_IDLE;
                end else if (accept) begin
                    if (bit_q == PAR_BIT) begin
                        bit_d = 5'd0;
                        if (par_q ^ cfg_if.tdi_v) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else if (cell_q == LAST_CELL) begin
                            state_d = ST_COMMIT;
                        end else begin
                            cell_d = cell_q + 1'b1;
                            par_d  = 1'b0;
                        end
                    end else begin
                        // Config bit lands directly in its final shadow position
                        for (int k = 0; k < NCELLS; k++) begin
                            for (int b = 0; b < CFGW; b++) begin
                                if (cell_q == CW'(k) && bit_q == 5'(b)) begin
                                    shadow_d[k*CFGW + b] = cfg_if.tdi_v;
                                end
                            end
                        end
                        par_d = par_q ^ cfg_if.tdi_v;
                        bit_d = bit_q + 5'd1;
                    end
                end
            end

            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (!cfg_if.abort_v) begin
                    cfg_d  = shadow_q;
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_v) begin
        if (!rstn_v) begin
            state_q  <= ST_IDLE;
            bit_q    <= 5'd0;
            cell_q   <= '0;
            par_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            shadow_q <= '0;
            cfg_q    <= '0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            cell_q   <= cell_d;
            par_q    <= par_d;
            err_q    <= err_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
        end
    end

    assign cfg_if.tready_v = (state_q == ST_SHIFT);
    assign cfg_if.busy_v   = (state_q == ST_SHIFT) || (state_q == ST_COMMIT);
    assign cfg_if.done_v   = done_q;
    assign cfg_if.err_v    = err_q;
    assign cfg_if.cfg_mux  = cfg_q;

endmodule

// File: tb/tb_cellcore_cfg_loader.sv
// Randomized and directed bench for cellcore_cfg_loader with a frame-level reference model.
module tb_cellcore_cfg_loader;

    localparam int NC = 2;
    localparam int W  = NC * 20;

    logic clk;
    logic rstn;

    cellcore_cfg_loader_if #(.NCELLS(NC)) bus ();

    cellcore_cfg_loader #(.NCELLS(NC), .CFGW(20)) dut (
        .clk_v  (clk),
        .rstn_v (rstn),
        .cfg_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 receiving frames, 2 waiting to commit
    int          m_mode = 0;
    bit          m_err  = 1'b0;
    bit          m_done = 1'b0;
    logic [W-1:0] m_live = '0;
    bit          m_frame[$];
    logic [19:0] m_cells[$];
    bit          m_par;
    logic [19:0] m_v;

    always @(posedge clk) begin
        cyc_n++;
        m_done = 1'b0;
        if (!rstn) begin
            m_mode = 0;
            m_err  = 1'b0;
            m_live = '0;
            m_frame.delete();
            m_cells.delete();
        end else begin
            case (m_mode)
                0: if (bus.start_v) begin
                    m_mode = 1;
                    m_err  = 1'b0;
                    m_frame.delete();
                    m_cells.delete();
                end
                1: if (bus.abort_v) begin
                    m_mode = 0;
                end else if (bus.tvalid_v) begin
                    m_frame.push_back(bus.tdi_v);
                    if (m_frame.size() == 21) begin
                        m_par = 1'b0;
                        foreach (m_frame[i]) m_par ^= m_frame[i];
                        if (m_par) begin
                            m_err  = 1'b1;
                            m_mode = 0;
                        end else begin
                            for (int i = 0; i < 20; i++) m_v[i] = m_frame[i];
                            m_cells.push_back(m_v);
                            m_frame.delete();
                            if (m_cells.size() == NC) m_mode = 2;
                        end
                    end
                end
                default: begin
                    if (!bus.abort_v) begin
                        for (int k = 0; k < NC; k++) m_live[k*20 +: 20] = m_cells[k];
                        m_done = 1'b1;
                    end
                    m_mode = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tready", 64'(bus.tready_v), 64'(m_mode == 1));
            chk("busy",   64'(bus.busy_v),   64'(m_mode != 0));
            chk("done",   64'(bus.done_v),   64'(m_done));
            chk("err",    64'(bus.err_v),    64'(m_err));
            chk("cfg_mux", 64'(bus.cfg_mux), 64'(m_live));
        end
        if (bus.done_v === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int start_cyc;

    // One complete load attempt. gap: 0 none, 1 every other cycle, 2 random.
    // abort_at/restart_at/reset_at: accepted-bit count at which to act, -1 for never.
    task automatic load(input logic [19:0] c0, input logic [19:0] c1, input bit flip1,
                        input int gap, input int abort_at, input int restart_at,
                        input int reset_at, input bit abort_commit);
        bit bits[$];
        logic [19:0] c;
        int ng;
        for (int k = 0; k < NC; k++) begin
            c = (k == 0) ? c0 : c1;
            for (int i = 0; i < 20; i++) bits.push_back(c[i]);
            bits.push_back((^c) ^ ((k == NC - 1) ? flip1 : 1'b0));
        end
        start_cyc = cyc_n;
        bus.start_v = 1'b1;
        cyc();
        bus.start_v = 1'b0;
        for (int n = 0; n < bits.size(); n++) begin
            if (n == abort_at) begin
                bus.abort_v = 1'b1;
                cyc();
                bus.abort_v = 1'b0;
                repeat (3) cyc();
                return;
            end
            if (n == reset_at) begin
                rstn = 1'b0;
                cyc();
                rstn = 1'b1;
                return;
            end
            ng = (gap == 1) ? 1 : (gap == 2) ? $urandom_range(0, 2) : 0;
            repeat (ng) begin
                bus.tdi_v = 1'($urandom);
                cyc();
            end
            bus.tvalid_v = 1'b1;
            bus.tdi_v    = bits[n];
            bus.start_v  = (n == restart_at);
            cyc();
            bus.tvalid_v = 1'b0;
            bus.start_v  = 1'b0;
        end
        bus.abort_v = abort_commit;
        cyc();
        bus.abort_v = 1'b0;
        repeat (3) cyc();
    endtask

    int d1, dn;

    initial begin
        rstn         = 1'b0;
        bus.start_v  = 1'b0;
        bus.abort_v  = 1'b0;
        bus.tdi_v    = 1'b0;
        bus.tvalid_v = 1'b0;
        repeat (2) cyc();
        chk("reset_cfg",   64'(bus.cfg_mux),  64'h0);
        chk("reset_tready", 64'(bus.tready_v), 64'h0);
        chk("reset_busy",  64'(bus.busy_v),   64'h0);
        chk("reset_err",   64'(bus.err_v),    64'h0);
        rstn = 1'b1;
        chk_en = 1'b1;
        cyc();

        // Clean two-cell load, no gaps
        dn = done_cnt;
        load(20'h5A5A5, 20'hFFFFF, 1'b0, 0, -1, -1, -1, 1'b0);
        chk("s1_cfg",   64'(bus.cfg_mux), 64'hFF_FFF5_A5A5);
        chk("s1_err",   64'(bus.err_v), 64'h0);
        chk("s1_ndone", 64'(done_cnt - dn), 64'd1);
        d1 = done_cyc - start_cyc;
        chk("s1_latency", 64'(d1), 64'd44);

        // Flipped parity on the last cell: error, no commit
        dn = done_cnt;
        load(20'h12345, 20'h0F0F0, 1'b1, 0, -1, -1, -1, 1'b0);
        chk("s2_err",   64'(bus.err_v), 64'h1);
        chk("s2_cfg",   64'(bus.cfg_mux), 64'hFF_FFF5_A5A5);
        chk("s2_ndone", 64'(done_cnt - dn), 64'd0);

        // Same stream as the first with a gap before every bit
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        cyc();
        load(20'h5A5A5, 20'hFFFFF, 1'b0, 1, -1, -1, -1, 1'b0);
        chk("s3_cfg",   64'(bus.cfg_mux), 64'hFF_FFF5_A5A5);
        chk("s3_latency", 64'(done_cyc - start_cyc), 64'(d1 + 42));

        // Abort after 30 bits, then a good load of new values
        load(20'h00001, 20'h00003, 1'b0, 0, 30, -1, -1, 1'b0);
        chk("s4_abort_cfg", 64'(bus.cfg_mux), 64'hFF_FFF5_A5A5);
        load(20'h12345, 20'hABCDE, 1'b0, 0, -1, -1, -1, 1'b0);
        chk("s4_cfg", 64'(bus.cfg_mux), 64'hAB_CDE1_2345);

        // Restart request mid-shift is ignored; then reset mid-load
        load(20'h11111, 20'h22222, 1'b0, 0, -1, 10, 25, 1'b0);
        chk("s5_rst_cfg",   64'(bus.cfg_mux),  64'h0);
        chk("s5_rst_busy",  64'(bus.busy_v),   64'h0);
        chk("s5_rst_tready", 64'(bus.tready_v), 64'h0);
        cyc();
        load(20'h11111, 20'h22222, 1'b0, 0, -1, 10, -1, 1'b0);
        chk("s5_cfg", 64'(bus.cfg_mux), 64'h22_2221_1111);

        // Abort landing on the commit cycle
        dn = done_cnt;
        load(20'h33333, 20'h44444, 1'b0, 0, -1, -1, -1, 1'b1);
        chk("s6_cfg",   64'(bus.cfg_mux), 64'h22_2221_1111);
        chk("s6_ndone", 64'(done_cnt - dn), 64'd0);
        chk("s6_busy",  64'(bus.busy_v), 64'h0);

        // Randomized loads: random data, gaps, parity faults and aborts
        for (int t = 0; t < 25; t++) begin
            load(20'($urandom), 20'($urandom), ($urandom_range(0, 3) == 0), 2,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 41)) : -1,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 41)) : -1,
                 -1, ($urandom_range(0, 7) == 0));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
